// File: rtl/merge3_arbiter.sv
// merge3_arbiter: 2:1 NoC flit merge with a round-robin grant and a 2-entry {sel,data} output skid buffer.
// Define MERGE3_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet (wormhole) until its tail flit.
module merge3_arbiter #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_sel,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic         space;
    logic         elig0;
    logic         elig1;
    logic         grant;
    logic         acc0;
    logic         acc1;
    logic         push;
    logic         pop;
    logic [W-1:0] push_data;
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         rr;
    logic [W-1:0] buf_data [DEPTH];
    logic         buf_sel  [DEPTH];

`ifdef MERGE3_ARBITER_PKT_LOCK_EN
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    state_t state;
    state_t state_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // A single-flit packet (tail on first flit) never takes the lock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc0 && !in0_data[W-1])      state_nxt = LOCK0;
                else if (acc1 && !in1_data[W-1]) state_nxt = LOCK1;
            end
            LOCK0:   if (acc0 && in0_data[W-1]) state_nxt = IDLE;
            LOCK1:   if (acc1 && in1_data[W-1]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign elig0 = in0_valid && (state != LOCK1);
    assign elig1 = in1_valid && (state != LOCK0);
`else
    assign elig0 = in0_valid;
    assign elig1 = in1_valid;
`endif

    // Space comes from the registered count only, so ready never sees out_ready.
    assign space     = !RESET && (count < FULL);
    assign grant     = (elig0 && elig1) ? ~rr : elig1;
    assign acc0      = space && elig0 && !grant;
    assign acc1      = space && elig1 && grant;
    assign in0_ready = acc0;
    assign in1_ready = acc1;
    assign push      = acc0 || acc1;
    assign push_data = acc1 ? in1_data : in0_data;

    assign out_valid = !RESET && (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_sel   = out_valid && buf_sel[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            rr     <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                rr     <= grant;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage carries no reset; count alone decides what is live.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_data[wr_ptr] <= push_data;
            buf_sel[wr_ptr]  <= acc1;
        end
    end
endmodule

// File: tb/tb_merge3_arbiter.sv
// Bench for merge3_arbiter: queue-based reference model checked every cycle, directed cases plus random stress.
module tb_merge3_arbiter;
`ifdef MERGE3_ARBITER_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [8:0] in0_data, in1_data;
    logic       in0_valid, in1_valid, out_ready;
    logic       in0_ready, in1_ready, out_sel, out_valid;
    logic [8:0] out_data;

    merge3_arbiter #(.W(9), .DEPTH(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [8:0] pend0[$], pend1[$];
    int pct0 = 0, pct1 = 0;
    bit rdy_rand = 0;
    bit took0 = 0, took1 = 0;

    logic [9:0] mq[$];
    logic       m_rr = 1'b1;
    int         m_lock = -1;
    logic [9:0] popped[$];
    logic [9:0] expq[$];
    int acc_cnt = 0;
    logic last_r0, last_r1, last_ov;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lock_upd(int k, logic tail);
        if (LOCK_EN) begin
            if (m_lock == -1 && !tail)     m_lock = k;
            else if (m_lock == k && tail)  m_lock = -1;
        end
    endfunction

    task automatic drive_inputs();
        if (took0 || !in0_valid) begin
            if (pend0.size() > 0 && $urandom_range(99) < pct0) begin
                in0_valid = 1'b1; in0_data = pend0[0];
            end else begin
                in0_valid = 1'b0; in0_data = 'x;
            end
        end
        if (took1 || !in1_valid) begin
            if (pend1.size() > 0 && $urandom_range(99) < pct1) begin
                in1_valid = 1'b1; in1_data = pend1[0];
            end else begin
                in1_valid = 1'b0; in1_data = 'x;
            end
        end
    endtask

    task automatic cycle();
        logic sp, e0, e1, g, x0, x1, ev;
        logic [9:0] h;
        drive_inputs();
        if (rdy_rand) out_ready = ($urandom_range(99) < 75);
        @(negedge CLK);
        sp = !RESET && (mq.size() < 2);
        e0 = in0_valid && (m_lock != 1);
        e1 = in1_valid && (m_lock != 0);
        g  = (e0 && e1) ? ~m_rr : e1;
        x0 = sp && e0 && !g;
        x1 = sp && e1 && g;
        ev = !RESET && (mq.size() != 0);
        h  = ev ? mq[0] : 10'h000;
        chk("in0_ready", in0_ready, x0);
        chk("in1_ready", in1_ready, x1);
        chk("out_valid", out_valid, ev);
        chk("out_sel", out_sel, h[9]);
        chk("out_data", out_data, h[8:0]);
        last_r0 = in0_ready; last_r1 = in1_ready; last_ov = out_valid;
        if (RESET) begin
            mq.delete(); m_rr = 1'b1; m_lock = -1;
        end else begin
            if (ev && out_ready) popped.push_back(mq.pop_front());
            if (x0) begin
                mq.push_back({1'b0, in0_data}); m_rr = 1'b0;
                void'(pend0.pop_front()); acc_cnt++; lock_upd(0, in0_data[8]);
            end
            if (x1) begin
                mq.push_back({1'b1, in1_data}); m_rr = 1'b1;
                void'(pend1.pop_front()); acc_cnt++; lock_upd(1, in1_data[8]);
            end
        end
        took0 = x0; took1 = x1;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(int n);
        RESET = 1'b1;
        repeat (n) cycle();
        RESET = 1'b0;
    endtask

    task automatic run_drain(string name, int max, output int cyc);
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (cyc < max && !(pend0.size() == 0 && pend1.size() == 0 && mq.size() == 0 &&
                                  (!in0_valid || took0) && (!in1_valid || took1)));
        if (cyc >= max) begin
            checks++; errors++;
            $display("FAIL %s: drain timeout after %0d cycles", name, cyc);
        end
    endtask

    task automatic chk_seq(string name);
        chk({name, "_len"}, popped.size(), expq.size());
        for (int i = 0; i < expq.size() && i < popped.size(); i++) chk(name, popped[i], expq[i]);
    endtask

    task automatic gen_pkts(int k, int n);
        int cnt = 0;
        while (cnt < n) begin
            int len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                logic [8:0] f;
                f = {(j == len - 1), 8'($urandom_range(0, 255))};
                if (k == 0) pend0.push_back(f); else pend1.push_back(f);
                cnt++;
            end
        end
    endtask

    initial begin
        int cyc, total;
        RESET = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; in0_data = 'x; in1_data = 'x; out_ready = 1'b0;
        do_reset(2);

        // single input, two flits
        out_ready = 1'b1; pct0 = 100; pct1 = 0;
        pend0 = '{9'h055, 9'h1AA};
        popped.delete();
        run_drain("t1", 50, cyc);
        expq = '{10'h055, 10'h1AA};
        chk_seq("t1_seq");

        // contention between single-flit packets
        do_reset(1);
        pct0 = 100; pct1 = 100;
        pend0 = '{9'h101, 9'h101, 9'h101, 9'h101};
        pend1 = '{9'h102, 9'h102, 9'h102, 9'h102};
        popped.delete();
        run_drain("t2", 50, cyc);
        chk("t2_cycles", cyc, 9);
        expq = '{10'h101, 10'h302, 10'h101, 10'h302, 10'h101, 10'h302, 10'h101, 10'h302};
        chk_seq("t2_seq");

        // multi-flit packet against a waiting single flit
        do_reset(1);
        pend0 = '{9'h011, 9'h012, 9'h113};
        pend1 = '{9'h1FF};
        popped.delete();
        run_drain("t3", 50, cyc);
        if (LOCK_EN) expq = '{10'h011, 10'h012, 10'h113, 10'h3FF};
        else         expq = '{10'h011, 10'h3FF, 10'h012, 10'h113};
        chk_seq("t3_seq");

        // downstream stall with both inputs streaming
        do_reset(1);
        out_ready = 1'b0;
        pend0 = '{9'h140, 9'h141, 9'h142, 9'h143, 9'h144, 9'h145};
        pend1 = '{9'h150, 9'h151, 9'h152, 9'h153, 9'h154, 9'h155};
        popped.delete(); acc_cnt = 0;
        repeat (5) cycle();
        chk("t4_stall_accepts", acc_cnt, 2);
        chk("t4_readys_low", {last_r0, last_r1}, 2'b00);
        out_ready = 1'b1;
        run_drain("t4", 100, cyc);
        chk("t4_drained", popped.size(), 12);

        // reset while full (and locked to input 1 when locking is built in)
        do_reset(1);
        out_ready = 1'b0; pct0 = 0; pct1 = 100;
        pend1 = '{9'h0AA, 9'h0BB, 9'h1CC};
        repeat (3) cycle();
        pend0 = '{9'h155}; pct0 = 100;
        RESET = 1'b1;
        cycle();
        chk("t5_ov_in_reset", last_ov, 1'b0);
        RESET = 1'b0; out_ready = 1'b1;
        popped.delete();
        cycle();
        chk("t5_r0_after", last_r0, 1'b1);
        chk("t5_r1_after", last_r1, 1'b0);
        run_drain("t5", 50, cyc);
        expq = '{10'h155, 10'h3CC};
        chk_seq("t5_seq");

        // random stress
        do_reset(1);
        gen_pkts(0, 5000); gen_pkts(1, 5000);
        total = pend0.size() + pend1.size();
        pct0 = 60; pct1 = 70; rdy_rand = 1;
        popped.delete();
        run_drain("stress", 60000, cyc);
        rdy_rand = 0;
        chk("stress_count", popped.size(), total);
`ifdef MERGE3_ARBITER_PKT_LOCK_EN
        begin
            int src = -1;
            for (int i = 0; i < popped.size(); i++) begin
                if (src != -1) chk("stress_contig", popped[i][9], src[0]);
                src = popped[i][8] ? -1 : int'(popped[i][9]);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/merge3_arbiter.md
Name: merge3_arbiter

Overview:
- Synchronous 2:1 merge for the 9-bit NoC flit path, the converse of the 1:2 routing decoder.
- Arbitrates two input flit channels onto one output channel.
- Tags each output flit with the index of the input it came from.
- Bit 8 of each flit is the tail flag. With packet lock enabled, a granted input holds the output until its tail flit passes (wormhole).

Parameters:
- W, 9, flit width including tail bit W-1.
- DEPTH, 2, output buffer entries; legal values are 2 only (skid pair).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous active-high reset.
- in0_data  input  W  flit from input 0.
- in0_valid  input  1  input 0 flit present.
- in0_ready  output  1  input 0 flit accepted this cycle when high with in0_valid.
- in1_data  input  W  flit from input 1.
- in1_valid  input  1  input 1 flit present.
- in1_ready  output  1  input 1 accept.
- out_data  output  W  merged flit.
- out_sel  output  1  source index of out_data (0 or 1).
- out_valid  output  1  output flit present.
- out_ready  input  1  downstream accept.

Behaviour:
- Handshake (all channels): transfer occurs when valid and ready are both high at a rising edge.
  - valid must not depend on ready.
  - Once raised, valid and data must be held until transfer.
  - in*_ready may depend combinationally on in*_valid of both inputs and on registered state only, never on out_ready.
- Output buffer: 2-entry FIFO of {sel, data}.
  - count in 0..2, registered.
  - space = (count < 2), from registered count. A full buffer does not accept even if popped the same cycle.
  - Simultaneous push and pop at count 1 leaves count 1.
  - out_valid = (count != 0). out_data/out_sel show the head entry.
- Latency: flit accepted at edge N appears on out_valid after edge N (visible in cycle N+1) when the buffer was empty.
- Throughput: 1 flit/cycle sustained while out_ready is held high.
- Grant: combinational, from valids, lock state and the rr pointer.
  - rr is 1 bit and holds the last granted index.
  - When both inputs are valid and unlocked, grant = ~rr. Otherwise grant goes to the single valid input.
  - in0_ready = space & grant==0 & in0_valid-eligible. in1_ready likewise.
  - Exactly one ready is high at most.
  - rr updates to the granted index on each accepted flit.
- Lock FSM (states IDLE, LOCK0, LOCK1):
  - IDLE: accepted non-tail flit from input k goes to LOCKk. Accepted tail flit (single-flit packet) stays in IDLE.
  - LOCKk: only input k is eligible; the other input's ready is held low even if valid. Accepted tail from k returns to IDLE.
  - Lock persists across empty cycles and full-buffer stalls.
- Reset (synchronous, RESET high at an edge):
  - count=0, FIFO contents don't-care, state=IDLE, rr=1 (input 0 wins first contention).
  - Outputs: out_valid=0, in0_ready=0, in1_ready=0 while RESET is high.
  - out_data and out_sel are driven 0 while out_valid=0.
  - Reset mid-packet discards buffered flits and the lock with no flush.
- Boundaries:
  - Both inputs valid and buffer full: no ready, rr unchanged.
  - out_ready high with count 0: no effect.
  - X on idle data is never propagated into out_sel.

Optional Feature:
- Macro MERGE3_ARBITER_PKT_LOCK_EN.
- Defined: lock FSM as above (wormhole packet integrity).
- Undefined: no FSM. Per-flit round-robin, the tail bit is passed through uninterpreted, and flits of two packets may interleave.

Test Plan:
- Reset then only in0 sends 0x055, 0x1AA (tail) with out_ready=1 → out 0x055 sel0 in cycle after accept, then 0x1AA sel0; in1_ready stays 0 throughout.
- Both inputs valid with single-flit packets, in0=0x101, in1=0x102, repeated, out_ready=1 → output alternates sel0,sel1,… starting sel0; one flit/cycle.
- PKT_LOCK_EN: in0 sends 0x011,0x012,0x113 while in1 holds 0x1FF valid → out order 0x011,0x012,0x113 (sel0), then 0x1FF sel1. Without macro: 0x011,0x1FF,0x012,0x113.
- out_ready=0 for 5 cycles with both inputs streaming → exactly 2 flits accepted, both readys low from next cycle; releasing out_ready drains in order with no loss or duplication.
- RESET asserted one cycle while count=2 and state=LOCK1 → next cycle out_valid=0, readys reflect IDLE with rr=1; contended flits go to in0 first.
- Random valid/out_ready stress, 10k flits, scoreboard per input → per-input order preserved, sel matches source, packet contiguity holds when the macro is defined.
